// File: rtl/aidc_lite_pkg.sv
// Shared definitions for the AIDC-lite compressor slice: block geometry,
// scheme tag, bus typedefs and the signed-fit helper.
package aidc_lite_pkg;

    localparam int   BLK_WORDS = 16;
    localparam logic SR_TAG    = 1'b0;

    typedef logic [31:0] beat_t;
    typedef logic [63:0] word_t;

    // True when v is representable as a signed value of 'bits' width,
    // i.e. v[15:bits-1] are all copies of the sign bit.
    function automatic logic sr_fit(input logic [15:0] v, input int unsigned bits);
        logic signed [15:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/aidc_lite_sr_lane.sv
// One sign-reduction lane: passes the low byte through and reports whether
// the 16-bit value fits (7 bits for the tagged lane of a sop word, else 8).
module aidc_lite_sr_lane
    import aidc_lite_pkg::*;
(
    input  logic [15:0] lane_i,
    input  logic        is_sop_i,
    output logic [7:0]  lane_o,
    output logic        fit_o
);

    always_comb begin
        lane_o = lane_i[7:0];
        fit_o  = is_sop_i ? sr_fit(lane_i, 7) : sr_fit(lane_i, 8);
    end

endmodule

// File: rtl/aidc_lite_comp_sr.sv
// Sign-reduction compressor: narrows each 64-bit word of a block to a 32-bit
// beat, tracks the beat index and whether every lane of the block fit.
module aidc_lite_comp_sr #(
    parameter logic TAG_BIT   = aidc_lite_pkg::SR_TAG,
    parameter int   BLK_WORDS = aidc_lite_pkg::BLK_WORDS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic [63:0]                  data_i,
    output logic                         valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic [$clog2(BLK_WORDS)-1:0] addr_o,
    output logic [31:0]                  data_o,
    output logic                         done_o,
    output logic                         ok_o
);
    import aidc_lite_pkg::*;

    localparam int ADDR_W = $clog2(BLK_WORDS);

    logic [3:0][7:0] lane_b;
    logic [3:0]      lane_fit;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        aidc_lite_sr_lane u_lane (
            .lane_i   (data_i[16*g +: 16]),
            .is_sop_i ((g == 3) ? sop_i : 1'b0),
            .lane_o   (lane_b[g]),
            .fit_o    (lane_fit[g])
        );
    end

    logic              valid_q, valid_d;
    logic              sop_q,   sop_d;
    logic              eop_q,   eop_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    beat_t             data_q,  data_d;
    logic              done_q,  done_d;
    logic              ok_q,    ok_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic              acc_q,   acc_d;

    logic [ADDR_W-1:0] cur_idx;
    logic              acc_new;

    // NOTE: every _d gets a default before any branch, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        done_d  = done_q;
        ok_d    = ok_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        cur_idx = sop_i ? '0 : cnt_q;
        acc_new = sop_i ? (&lane_fit) : (acc_q & (&lane_fit));

        if (valid_i) begin
            valid_d = 1'b1;
            sop_d   = sop_i;
            eop_d   = eop_i;
            addr_d  = cur_idx;
            data_d  = sop_i ? {TAG_BIT, lane_b[3][6:0], lane_b[2], lane_b[1], lane_b[0]}
                            : {lane_b[3], lane_b[2], lane_b[1], lane_b[0]};
            acc_d   = acc_new;
            // Over-long blocks wrap silently; the sop resync realigns them.
            if (eop_i || cur_idx == ADDR_W'(BLK_WORDS - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cur_idx + 1'b1;
            end
            if (eop_i) begin
                done_d = 1'b1;
                ok_d   = acc_new;
            end else if (sop_i) begin
                done_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous
    // active-low reset; the fit accumulator resets to 1 (nothing failed yet).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 1'b1;
        end else begin
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign valid_o = valid_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign done_o  = done_q;
    assign ok_o    = ok_q;

endmodule

// File: tb/tb_aidc_lite_comp_sr.sv
// Bench for aidc_lite_comp_sr: directed block scenarios, then random blocks
// checked against a word-level model and a behavioural SR decompressor.
module tb_aidc_lite_comp_sr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, sop_i, eop_i;
    logic [63:0] data_i;
    logic        valid_o, sop_o, eop_o, done_o, ok_o;
    logic [3:0]  addr_o;
    logic [31:0] data_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: position in block, running fit, done/ok levels.
    int m_idx;
    bit m_acc, m_done, m_ok;

    aidc_lite_comp_sr #(.TAG_BIT(1'b0), .BLK_WORDS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .done_o  (done_o),
        .ok_o    (ok_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit lane_fits(input logic [15:0] lane, input int bits);
        int sv;
        sv = int'($signed(lane));
        return (sv >= -(1 << (bits - 1))) && (sv < (1 << (bits - 1)));
    endfunction

    function automatic bit word_fits(input logic [63:0] d, input bit s);
        return lane_fits(d[63:48], s ? 7 : 8) && lane_fits(d[47:32], 8) &&
               lane_fits(d[31:16], 8) && lane_fits(d[15:0], 8);
    endfunction

    function automatic logic [31:0] pack(input logic [63:0] d, input bit s);
        logic [31:0] b;
        b = {d[55:48], d[39:32], d[23:16], d[7:0]};
        if (s) b[31] = 1'b0;
        return b;
    endfunction

    // Receiver side: sign-extend each byte (the tagged lane from 7 bits).
    function automatic logic [63:0] unpack(input logic [31:0] b, input bit s);
        logic [15:0] v3;
        v3 = s ? {{9{b[30]}}, b[30:24]} : {{8{b[31]}}, b[31:24]};
        return {v3, {8{b[23]}}, b[23:16], {8{b[15]}}, b[15:8], {8{b[7]}}, b[7:0]};
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_acc  = 1'b1;
        m_done = 1'b0;
        m_ok   = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_sop"},   sop_o,   0);
        check({tag, "_eop"},   eop_o,   0);
        check({tag, "_addr"},  addr_o,  0);
        check({tag, "_data"},  data_o,  0);
    endtask

    // Present one input cycle, advance the model, then check all outputs.
    task automatic step(input bit v, input bit s, input bit e, input logic [63:0] d);
        int          cur;
        bit          fit;
        logic [31:0] exp_data;
        @(negedge clk);
        valid_i = v; sop_i = s; eop_i = e; data_i = d;
        cur = 0;
        exp_data = '0;
        if (v) begin
            cur = s ? 0 : m_idx;
            fit = word_fits(d, s);
            m_acc = s ? fit : (m_acc && fit);
            m_idx = e ? 0 : (cur + 1) % 16;
            if (e) begin
                m_done = 1'b1;
                m_ok   = m_acc;
            end else if (s) begin
                m_done = 1'b0;
            end
            exp_data = pack(d, s);
        end
        @(posedge clk);
        #1;
        check("valid_o", valid_o, v);
        check("sop_o",   sop_o,   v & s);
        check("eop_o",   eop_o,   v & e);
        check("addr_o",  addr_o,  cur);
        check("data_o",  data_o,  exp_data);
        check("done_o",  done_o,  m_done);
        if (m_done) check("ok_o", ok_o, m_ok);
    endtask

    function automatic logic [15:0] rnd_lane(input int bits, input bit wild);
        int r;
        if (wild) return 16'($urandom);
        r = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
        return 16'(r);
    endfunction

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_done", done_o, 0);
        check("reset_ok",   ok_o,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: sixteen small words
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, i == 15, {4{16'h0005}});
            check("t1_addr", addr_o, i);
            if (i == 0)  check("t1_beat0", data_o, 32'h0505_0505);
        end
        check("t1_done", done_o, 1);
        check("t1_ok",   ok_o,   1);

        // 2: +128 in lane 1 of word 3 still emitted, block flagged
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, i == 15, (i == 3) ? 64'h0005_0005_0080_0005 : {4{16'h0005}});
            if (i == 1) check("t2_done_cleared", done_o, 0);
            if (i == 3) check("t2_beat3", data_o, 32'h0505_8005);
        end
        check("t2_done", done_o, 1);
        check("t2_ok",   ok_o,   0);

        // 3: tagged lane limited to 7 bits only on the sop word
        step(1, 1, 0, 64'h0040_0000_0000_0000);
        step(1, 0, 1, 64'h0);
        check("t3_sop_overflow_ok", ok_o, 0);
        step(1, 1, 0, 64'h0);
        step(1, 0, 1, 64'h0040_0000_0000_0000);
        check("t3_nonsop_ok", ok_o, 1);
        step(1, 1, 0, 64'hFFC0_0000_0000_0000);
        step(1, 0, 1, 64'h0);
        check("t3_sop_neg_ok", ok_o, 1);

        // 4: one-word block
        step(1, 1, 1, 64'hFFFF_FFFE_0001_007F);
        check("t4_data", data_o, 32'h7FFE_017F);
        check("t4_addr", addr_o, 0);
        check("t4_done", done_o, 1);
        check("t4_ok",   ok_o,   1);

        // 5: idle gaps, then reset arriving with word 7
        for (int i = 0; i < 7; i++) begin
            step(1, i == 0, 0, {4{16'(i)}});
            step(0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D);
            check_idle("t5_gap");
        end
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b1; sop_i = 1'b0; eop_i = 1'b0; data_i = {4{16'h0007}};
        @(posedge clk);
        #1;
        check_idle("t5_reset");
        check("t5_reset_done", done_o, 0);
        check("t5_reset_ok",   ok_o,   0);
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b0;
        model_reset();
        step(1, 0, 0, {4{16'h0001}});
        check("t5_restart_addr", addr_o, 0);
        step(1, 0, 1, {4{16'h0002}});

        // Over-long block: index wraps 15 -> 0
        for (int i = 0; i < 20; i++) begin
            step(1, i == 0, i == 19, {4{16'hFFF0}});
            if (i == 16) check("wrap_addr", addr_o, 0);
        end
        check("wrap_ok", ok_o, 1);

        // 6: random blocks, round trip through the behavioural decompressor
        for (int b = 0; b < 1000; b++) begin
            int len;
            bit wild_blk;
            len = int'($urandom_range(1, 16));
            wild_blk = ($urandom_range(0, 9) == 0);
            for (int w = 0; w < len; w++) begin
                logic [63:0] d;
                bit          s;
                s = (w == 0);
                if ($urandom_range(0, 3) == 0) begin
                    step(0, 0, 0, {$urandom, $urandom});
                    check_idle("rt_gap");
                end
                d = {rnd_lane(s ? 7 : 8, wild_blk && $urandom_range(0, 3) == 0),
                     rnd_lane(8, wild_blk && $urandom_range(0, 3) == 0),
                     rnd_lane(8, 1'b0),
                     rnd_lane(8, wild_blk && $urandom_range(0, 3) == 0)};
                step(1, s, w == len - 1, d);
                if (word_fits(d, s)) check("rt_word", unpack(data_o, s), d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
